// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional skid buffer is enabled with FETCH_BUF_EN (see fetch_unit.sv).
package fetch_pkg;

  localparam int INS_W  = 64;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0]  MEM_LATENCY   = 3'd5;
  localparam logic [ADDR_W-1:0] PC_STEP       = 16'd8;
  localparam logic [ADDR_W-1:0] RESET_PC      = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = 16'hFFF8;

  typedef struct packed {
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_latency_counter.sv
// Counts edges the memory has seen the current address; saturates at MEM_LATENCY.
// clr_i wins over set1_i; set1_i models the memory restarting on a refetch edge.
module fetch_latency_counter
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic set1_i,
  output logic data_valid_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (set1_i)              cnt_d = 3'd1;
    else if (cnt_q < MEM_LATENCY) cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign data_valid_o = (cnt_q == MEM_LATENCY);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, times the fixed-latency memory, feeds IF/ID.
// Define FETCH_BUF_EN to add a 1-entry skid buffer instead of refetching on stall.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [15:0]       mem_addr,
  input  logic [63:0]       mem_ins,
  input  logic              id_ready,
  input  logic              branch_taken,
  input  logic [15:0]       branch_target,
  output logic              if_valid,
  output logic [63:0]       if_ins,
  output logic [15:0]       if_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [INS_W-1:0]  if_ins_q, if_ins_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              data_valid, slot_free, cnt_clr, cnt_set1;

  fetch_latency_counter u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .set1_i       (cnt_set1),
    .data_valid_o (data_valid)
  );

  assign slot_free = !if_valid_q || id_ready;

`ifdef FETCH_BUF_EN
  fetch_entry_t buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;

  always_comb begin
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    if_ins_d    = if_ins_q;
    if_pc_d     = if_pc_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    cnt_clr     = 1'b0;
    cnt_set1    = 1'b0;
    if (branch_taken) begin
      pc_d        = align_pc(branch_target);
      cnt_clr     = 1'b1;
      if_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
    end else if (slot_free && buf_valid_q) begin
      // Older buffered word goes out first; a word arriving now refills the buffer.
      if_ins_d    = buf_q.ins;
      if_pc_d     = buf_q.pc;
      if_valid_d  = 1'b1;
      buf_valid_d = 1'b0;
      if (data_valid) begin
        buf_d       = '{ins: mem_ins, pc: pc_q};
        buf_valid_d = 1'b1;
        pc_d        = pc_q + PC_STEP;
        cnt_clr     = 1'b1;
      end
    end else if (data_valid && slot_free) begin
      if_ins_d   = mem_ins;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_STEP;
      cnt_clr    = 1'b1;
    end else if (data_valid && !buf_valid_q) begin
      buf_d       = '{ins: mem_ins, pc: pc_q};
      buf_valid_d = 1'b1;
      pc_d        = pc_q + PC_STEP;
      cnt_clr     = 1'b1;
    end else if (!data_valid && id_ready && if_valid_q) begin
      if_valid_d = 1'b0;
    end
    // Both stages full with data valid: hold; the counter stays saturated.
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`else
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_ins_d   = if_ins_q;
    if_pc_d    = if_pc_q;
    cnt_clr    = 1'b0;
    cnt_set1   = 1'b0;
    if (branch_taken) begin
      pc_d       = align_pc(branch_target);
      cnt_clr    = 1'b1;
      if_valid_d = 1'b0;
    end else if (data_valid && slot_free) begin
      if_ins_d   = mem_ins;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_STEP;
      cnt_clr    = 1'b1;
    end else if (data_valid) begin
      // Memory drops the word after this edge and starts counting again.
      cnt_set1 = 1'b1;
    end else if (id_ready && if_valid_q) begin
      if_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_ins_q   <= '0;
      if_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_ins_q   <= if_ins_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign mem_addr = pc_q;
  assign if_valid = if_valid_q;
  assign if_ins   = if_ins_q;
  assign if_pc    = if_pc_q;

endmodule
